// File: rtl/aes_cone_match_pipe.sv
// Two-stage pipelined pattern matcher feeding an AOI22 cone, with a
// runtime-loadable mask/pattern and a saturating hit counter.
module aes_cone_match_pipe #(
    parameter int               WIDTH     = 10,
    parameter int               CNT_W     = 8,
    parameter logic [WIDTH-1:0] RST_MASK  = '1,
    parameter logic [WIDTH-1:0] RST_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [WIDTH-1:0] cfg_mask,
    input  logic [WIDTH-1:0] cfg_value,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_a,
    input  logic             in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_y,
    output logic             out_match,
    input  logic             clr_count,
    output logic [CNT_W-1:0] hit_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] value_q;
    logic             match_c;
    logic             s1_valid;
    logic             s1_match;
    logic             s1_ab;
    logic             s1_load;
    logic             s2_load;
    logic             out_xfer;

    // Handshake: a transfer happens on a port only when valid and ready are both
    // high in the same cycle; in_ready never looks at in_valid.
    assign s2_load  = ~out_valid | out_ready;
    assign s1_load  = ~s1_valid | s2_load;
    assign in_ready = s1_load;
    assign out_xfer = out_valid & out_ready;

    // Masked-off bits always agree, so an all-zero mask matches everything.
    assign match_c = &(~mask_q | ~(in_data ^ value_q));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask_q  <= RST_MASK;
            value_q <= RST_VALUE;
        end else if (cfg_we) begin
            mask_q  <= cfg_mask;
            value_q <= cfg_value;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_match <= 1'b0;
            s1_ab    <= 1'b0;
        end else if (s1_load) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_match <= match_c;
                s1_ab    <= in_a & in_b;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_y     <= 1'b1;
            out_match <= 1'b0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_y     <= ~(s1_ab | s1_match);
                out_match <= s1_match;
            end
        end
    end

    // Clear has priority over a counting transfer in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count <= '0;
        end else if (clr_count) begin
            hit_count <= '0;
        end else if (out_xfer && out_match && (hit_count != CNT_MAX)) begin
            hit_count <= hit_count + CNT_W'(1);
        end
    end

endmodule
